packet_stream_source: RTL and testbench

PACKET_STREAM_SOURCE -- requirements
Module: packet_stream_source

---
 rtl/packet_stream_source.sv | 173 +++++++++++++++++
 tb/tb_packet_stream_source.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_stream_source.sv
// Avalon-ST packet source. Software loads words through an Avalon-MM CSR port,
// then emits them as one packet of LENGTH bytes with sop/eop/empty framing.
module packet_stream_source #(
    parameter int DATAWIDTH          = 32,
    parameter int DEPTH              = 64,
    parameter int SLAVE_ADDRESSWIDTH = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SLAVE_ADDRESSWIDTH-1:0] slave_address,
    input  logic [DATAWIDTH-1:0]          slave_writedata,
    input  logic                          slave_write,
    input  logic                          slave_read,
    input  logic                          slave_chipselect,
    output logic [DATAWIDTH-1:0]          slave_readdata,
    output logic [31:0]                   st_data,
    output logic                          st_valid,
    output logic                          st_sop,
    output logic                          st_eop,
    output logic [1:0]                    st_empty,
    input  logic                          st_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int LW = FW + 2;

    localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_DATA      = SLAVE_ADDRESSWIDTH'(0);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_LENGTH    = SLAVE_ADDRESSWIDTH'(1);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_CONTROL   = SLAVE_ADDRESSWIDTH'(2);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_STATUS    = SLAVE_ADDRESSWIDTH'(3);
    localparam logic [SLAVE_ADDRESSWIDTH-1:0] ADDR_PKT_COUNT = SLAVE_ADDRESSWIDTH'(4);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, next_state;
    logic [DATAWIDTH-1:0]  mem [DEPTH];
    logic [FW-1:0]         fill;          // also the write pointer
    logic [FW-1:0]         beat_idx;      // read pointer within the packet
    logic [FW-1:0]         pkt_beats;
    logic [1:0]            pkt_empty;
    logic [DATAWIDTH-1:0]  length_reg;
    logic [31:0]           pkt_count;
    logic                  done, error;

    logic                  wr, rd;
    logic                  data_wr, len_wr, ctrl_wr, stat_wr;
    logic                  clear_req, start_req, start_ok, start_err;
    logic                  push_ok, push_err;
    logic                  last_beat, beat_xfer, eop_xfer;
    logic                  len_ok;
    logic [FW-1:0]         fill_eff;
    logic [LW:0]           len_lo_ext, beats_req;
    logic [DATAWIDTH-1:0]  status, rdata_next;

    assign wr      = slave_write && slave_chipselect;
    assign rd      = slave_read && slave_chipselect;
    assign data_wr = wr && (slave_address == ADDR_DATA);
    assign len_wr  = wr && (slave_address == ADDR_LENGTH);
    assign ctrl_wr = wr && (slave_address == ADDR_CONTROL);
    assign stat_wr = wr && (slave_address == ADDR_STATUS);

    // Clear is applied before the start check, so start+clear always fails.
    assign clear_req  = ctrl_wr && slave_writedata[1] && (state == IDLE);
    assign start_req  = ctrl_wr && slave_writedata[0] && (state == IDLE);
    assign fill_eff   = clear_req ? '0 : fill;
    assign len_ok     = (length_reg != '0) && (length_reg <= DATAWIDTH'(4 * DEPTH));
    assign len_lo_ext = {1'b0, length_reg[LW-1:0]};
    assign beats_req  = (len_lo_ext + (LW+1)'(3)) >> 2;
    assign start_ok   = start_req && len_ok && (beats_req <= (LW+1)'(fill_eff));
    assign start_err  = start_req && !start_ok;

    assign push_ok  = data_wr && (state == IDLE) && (fill < FW'(DEPTH));
    assign push_err = data_wr && !push_ok;

    assign last_beat = (beat_idx == pkt_beats - FW'(1));
    assign beat_xfer = (state == SEND) && st_ready;
    assign eop_xfer  = beat_xfer && last_beat;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        st_valid   = 1'b0;
        st_sop     = 1'b0;
        st_eop     = 1'b0;
        st_empty   = 2'd0;
        st_data    = '0;
        unique case (state)
            IDLE: if (start_ok) next_state = SEND;
            SEND: begin
                st_valid = 1'b1;
                st_sop   = (beat_idx == '0);
                st_eop   = last_beat;
                st_empty = last_beat ? pkt_empty : 2'd0;
                st_data  = mem[beat_idx[AW-1:0]][31:0];
                if (st_ready && last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the buffer RAM carries no reset so it can map onto memory primitives.
    always_ff @(posedge clk) begin
        if (push_ok) mem[fill[AW-1:0]] <= slave_writedata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill       <= '0;
            beat_idx   <= '0;
            pkt_beats  <= '0;
            pkt_empty  <= 2'd0;
            length_reg <= '0;
            pkt_count  <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (len_wr) length_reg <= slave_writedata;

            if (eop_xfer) begin
                fill      <= '0;
                beat_idx  <= '0;
                pkt_count <= pkt_count + 32'd1;
            end else if (clear_req) begin
                fill     <= '0;
                beat_idx <= '0;
            end else if (push_ok) begin
                fill <= fill + FW'(1);
            end else if (beat_xfer) begin
                beat_idx <= beat_idx + FW'(1);
            end

            if (start_ok) begin
                pkt_beats <= beats_req[FW-1:0];
                pkt_empty <= 2'(3'd4 - {1'b0, length_reg[1:0]});
            end

            if (eop_xfer)                          done <= 1'b1;
            else if (start_ok)                     done <= 1'b0;
            else if (stat_wr && slave_writedata[1]) done <= 1'b0;

            // A new error in the same cycle as its W1C takes priority.
            if (push_err || start_err)             error <= 1'b1;
            else if (stat_wr && slave_writedata[2]) error <= 1'b0;
        end
    end

    always_comb begin
        status        = '0;
        status[0]     = (state == SEND);
        status[1]     = done;
        status[2]     = error;
        status[8 +: FW] = fill;
        rdata_next    = '0;
        unique case (slave_address)
            ADDR_LENGTH:    rdata_next = length_reg;
            ADDR_STATUS:    rdata_next = status;
            ADDR_PKT_COUNT: rdata_next = DATAWIDTH'(pkt_count);
            default:        rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)  slave_readdata <= '0;
        else if (rd)   slave_readdata <= rdata_next;
    end

endmodule

// File: tb/tb_packet_stream_source.sv
// Self-checking bench for packet_stream_source: directed scenarios plus random
// packets, compared against a queue-based model of buffer, CSRs and framing.
module tb_packet_stream_source;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] slave_address = '0;
    logic [DW-1:0] slave_writedata = '0;
    logic          slave_write = 1'b0, slave_read = 1'b0, slave_chipselect = 1'b0;
    logic [DW-1:0] slave_readdata;
    logic [31:0]   st_data;
    logic          st_valid, st_sop, st_eop;
    logic [1:0]    st_empty;
    logic          st_ready = 1'b0;

    always #5 clk = ~clk;

    packet_stream_source #(.DATAWIDTH(DW), .DEPTH(DEPTH), .SLAVE_ADDRESSWIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .slave_address(slave_address), .slave_writedata(slave_writedata),
        .slave_write(slave_write), .slave_read(slave_read),
        .slave_chipselect(slave_chipselect), .slave_readdata(slave_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
        .st_empty(st_empty), .st_ready(st_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    // Reference model state
    logic [31:0] m_buf[$];
    beat_t       exp_beats[$];
    int          beat_idx;
    logic [31:0] m_len;
    logic        m_done, m_err, m_busy;
    logic [31:0] m_cnt;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_buf.delete();
        exp_beats.delete();
        beat_idx = 0;
        m_len = '0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_cnt = '0;
    endtask

    task automatic model_start();
        longint need;
        int     r;
        beat_t  b;
        need = (longint'(m_len) + 3) / 4;
        if (m_len >= 1 && m_len <= 4 * DEPTH && need <= m_buf.size()) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            exp_beats.delete();
            beat_idx = 0;
            r = int'(m_len % 4);
            for (int i = 0; i < need; i++) begin
                b.data  = m_buf[i];
                b.sop   = (i == 0);
                b.eop   = (i == need - 1);
                b.empty = (b.eop && r != 0) ? 2'(4 - r) : 2'd0;
                exp_beats.push_back(b);
            end
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
        case (a)
            3'd0: if (m_busy || m_buf.size() >= DEPTH) m_err = 1'b1;
                  else m_buf.push_back(d);
            3'd1: m_len = d;
            3'd2: if (!m_busy) begin
                      if (d[1]) m_buf.delete();
                      if (d[0]) model_start();
                  end
            3'd3: begin
                      if (d[1]) m_done = 1'b0;
                      if (d[2]) m_err = 1'b0;
                  end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_status();
        logic [7:0] f;
        f = 8'(m_buf.size());
        return {16'd0, f, 5'd0, m_err, m_done, m_busy};
    endfunction

    task automatic csr_write(input logic [AW-1:0] a, input logic [31:0] d);
        slave_address = a; slave_writedata = d;
        slave_write = 1'b1; slave_chipselect = 1'b1;
        model_write(a, d);
        tick();
        slave_write = 1'b0; slave_chipselect = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        slave_address = a; slave_read = 1'b1; slave_chipselect = 1'b1;
        tick();
        slave_read = 1'b0; slave_chipselect = 1'b0;
        check(tag, slave_readdata, exp);
    endtask

    task automatic check_idle(input string tag);
        check(tag, {st_valid, st_sop, st_eop, st_empty, st_data}, '0);
    endtask

    // One cycle on the stream: compare the presented beat, then clock it.
    task automatic beat_cycle(input logic rdy);
        beat_t b;
        st_ready = rdy;
        #1;
        b = exp_beats[beat_idx];
        check("st_valid", st_valid, 1'b1);
        check($sformatf("beat%0d", beat_idx), {st_sop, st_eop, st_empty, st_data},
              {b.sop, b.eop, b.empty, b.data});
        tick();
        if (rdy) begin
            beat_idx++;
            if (beat_idx == exp_beats.size()) begin
                m_busy = 1'b0; m_done = 1'b1; m_cnt++; m_buf.delete();
            end
        end
    endtask

    task automatic send_rest(input int ready_pct);
        int cycles = 0;
        while (m_busy && cycles < 4000) begin
            beat_cycle($urandom_range(0, 99) < ready_pct);
            cycles++;
        end
        if (cycles >= 4000) check("send_timeout", beat_idx, exp_beats.size());
        st_ready = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) csr_write(3'd0, $urandom);
    endtask

    initial begin
        logic [31:0] len;
        int          n, r;

        model_reset();
        repeat (3) tick();
        check_idle("reset_st");
        check("reset_rdata", slave_readdata, 32'h0);
        reset_n = 1'b1;
        tick();
        read_check("reset_length", 3'd1, 32'h0);
        read_check("reset_status", 3'd3, 32'h0);
        read_check("reset_pktcnt", 3'd4, 32'h0);

        // Two-word, 7-byte packet with ready held high
        csr_write(3'd0, 32'h11223344);
        csr_write(3'd0, 32'h55667788);
        csr_write(3'd1, 32'd7);
        read_check("r031_fill", 3'd3, 32'h0000_0200);
        csr_write(3'd2, 32'h1);
        check("r031_b0", {st_valid, st_sop, st_eop, st_empty, st_data}, {5'b11000, 32'h11223344});
        beat_cycle(1'b1);
        check("r031_b1", {st_valid, st_sop, st_eop, st_empty, st_data}, {5'b10101, 32'h55667788});
        beat_cycle(1'b1);
        st_ready = 1'b0;
        check_idle("r031_after");
        read_check("r031_status", 3'd3, 32'h2);
        read_check("r031_pktcnt", 3'd4, 32'd1);

        // Single beat held under backpressure for two cycles
        csr_write(3'd1, 32'd4);
        csr_write(3'd0, 32'hCAFEF00D);
        csr_write(3'd2, 32'h1);
        beat_cycle(1'b0);
        beat_cycle(1'b0);
        check("r032_b0", {st_valid, st_sop, st_eop, st_empty, st_data}, {5'b11100, 32'hCAFEF00D});
        beat_cycle(1'b1);
        st_ready = 1'b0;
        check_idle("r032_after");

        // Length needs more words than buffered
        push_words(2);
        csr_write(3'd1, 32'd12);
        csr_write(3'd2, 32'h1);
        for (int i = 0; i < 3; i++) begin
            check_idle("r033_idle");
            tick();
        end
        read_check("r033_status", 3'd3, 32'h0000_0206);
        csr_write(3'd3, 32'h4);
        read_check("r033_w1c", 3'd3, exp_status());
        check("r033_err_model", m_err, 1'b0);

        // Readdata holds without a read; unmapped reads return 0
        repeat (3) tick();
        check("rdata_hold", slave_readdata, 32'h0000_0202);
        read_check("unmapped_5", 3'd5, 32'h0);
        read_check("data_read", 3'd0, 32'h0);
        read_check("ctrl_read", 3'd2, 32'h0);

        // Full buffer, overflow write, maximum-length packet without bubbles
        csr_write(3'd2, 32'h2);
        push_words(DEPTH);
        csr_write(3'd0, 32'hDEADBEEF);
        read_check("r034_status", 3'd3, 32'h0000_4006);
        csr_write(3'd1, 32'd256);
        csr_write(3'd2, 32'h1);
        for (int i = 0; i < DEPTH; i++) beat_cycle(1'b1);
        st_ready = 1'b0;
        check("r034_beats", beat_idx, DEPTH);
        check_idle("r034_after");
        read_check("r034_pktcnt", 3'd4, 32'd3);
        csr_write(3'd3, 32'h6);

        // DATA write and clear during SEND are ignored
        push_words(4);
        csr_write(3'd1, 32'd16);
        csr_write(3'd2, 32'h1);
        beat_cycle(1'b1);
        beat_cycle(1'b1);
        st_ready = 1'b0;
        csr_write(3'd0, 32'h12345678);
        csr_write(3'd2, 32'h2);
        read_check("r035_status", 3'd3, 32'h0000_0405);
        send_rest(100);
        check_idle("r035_after");
        read_check("r035_status2", 3'd3, exp_status());
        csr_write(3'd3, 32'h6);

        // Start and clear in the same write
        push_words(2);
        csr_write(3'd1, 32'd4);
        csr_write(3'd2, 32'h3);
        check_idle("r026_idle");
        read_check("r026_status", 3'd3, 32'h4);
        csr_write(3'd3, 32'h4);

        // Reset in the middle of a packet
        push_words(3);
        csr_write(3'd1, 32'd12);
        csr_write(3'd2, 32'h1);
        beat_cycle(1'b1);
        st_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        check_idle("r036_st");
        check("r036_rdata", slave_readdata, 32'h0);
        reset_n = 1'b1;
        model_reset();
        read_check("r036_length", 3'd1, 32'h0);
        read_check("r036_status", 3'd3, 32'h0);
        read_check("r036_pktcnt", 3'd4, 32'h0);

        // Random packets with random backpressure
        for (int it = 0; it < 25; it++) begin
            csr_write(3'd2, 32'h2);
            n = $urandom_range(0, 12);
            push_words(n);
            r = $urandom_range(0, 9);
            if (r == 0)      len = 32'd0;
            else if (r == 1) len = 32'(4 * n + $urandom_range(1, 4));
            else if (r == 2) len = 32'($urandom_range(257, 1000));
            else             len = 32'($urandom_range(1, (n > 0) ? 4 * n : 1));
            csr_write(3'd1, len);
            csr_write(3'd2, 32'h1);
            if (m_busy) begin
                send_rest(60);
                check_idle("rand_after");
            end else begin
                check_idle("rand_rejected");
            end
            read_check("rand_status", 3'd3, exp_status());
            read_check("rand_pktcnt", 3'd4, m_cnt);
            read_check("rand_length", 3'd1, m_len);
            if ($urandom_range(0, 1) == 1) csr_write(3'd3, 32'h6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
